// File: rtl/vram_write_sched.sv
// vram_write_sched: builds the 32-bit VRAM write word for the screen block.
// It shares one write slot per cycle between CPU single-pixel writes and a
// rectangle-fill engine, and it inserts the frame-swap marker word.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   pix_valid/ready    CPU pixel handshake (ready is combinational)
//   pix_x/y/color      CPU pixel coordinates and colour index
//   fill_start         one-cycle fill command strobe (ignored while busy)
//   fill_x0/y0/w/h     fill rectangle origin and size
//   fill_color         fill colour index
//   fill_busy          fill in progress (through the fill_done cycle)
//   fill_done          one-cycle completion pulse
//   swap_req           frame-swap request; repeated requests merge
//   info               registered write word (32'h0 means no write)
module vram_write_sched #(
  parameter int unsigned X_LO = 76,
  parameter int unsigned X_HI = 511,
  parameter int unsigned Y_LO = 100,
  parameter int unsigned Y_HI = 379
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [3:0]  pix_color,
  input  logic        fill_start,
  input  logic [9:0]  fill_x0,
  input  logic [9:0]  fill_y0,
  input  logic [9:0]  fill_w,
  input  logic [9:0]  fill_h,
  input  logic [3:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  input  logic        swap_req,
  output logic [31:0] info
);

  localparam int unsigned CW = 10;  // coordinate width
  localparam int unsigned SW = 11;  // coordinate sum width, never wraps

  localparam logic [31:0] SWAP_WORD = 32'h8000_0000;
  localparam logic        TURN_CPU  = 1'b0;
  localparam logic        TURN_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2
  } state_t;

  state_t          state_q;
  logic            turn_q;
  logic            swap_pend_q;
  logic [31:0]     info_q;
  logic            fill_busy_q;
  logic            fill_done_q;
  logic [CW-1:0]   f_x0_q;
  logic [CW-1:0]   f_y0_q;
  logic [CW-1:0]   f_w_q;
  logic [CW-1:0]   f_h_q;
  logic [3:0]      f_color_q;
  logic [CW-1:0]   col_q;
  logic [CW-1:0]   row_q;

  logic            pix_ready_c;
  logic            cpu_grant_c;
  logic            fill_accept_c;
  logic            fill_empty_c;
  logic            fill_last_c;
  logic            in_win_c;
  logic [SW-1:0]   cx_c;
  logic [SW-1:0]   cy_c;
  logic [31:0]     fill_word_c;
  logic            unused_c;

  // Word layout: swap at 31, {x,0} at 27:18, {y,0} at 17:8, colour at 3:0.
  function automatic logic [31:0] pack_word(input logic [8:0] x,
                                            input logic [8:0] y,
                                            input logic [3:0] c);
    return {4'b0000, x, 1'b0, y, 1'b0, 4'b0000, c};
  endfunction

  // CPU owns the slot in IDLE, and in FILL only when it is the CPU's turn.
  always_comb begin
    pix_ready_c = 1'b0;
    if (rst_n) begin
      pix_ready_c = (state_q == IDLE) || ((state_q == FILL) && (turn_q == TURN_CPU));
    end
  end

  // Fill scan position, clip test and end-of-scan detection.
  always_comb begin
    cpu_grant_c   = pix_valid && pix_ready_c;
    fill_accept_c = (state_q == IDLE) && fill_start && !fill_busy_q;
    fill_empty_c  = (f_w_q == CW'(0)) || (f_h_q == CW'(0));
    cx_c          = SW'(f_x0_q) + SW'(col_q);
    cy_c          = SW'(f_y0_q) + SW'(row_q);
    in_win_c      = (cx_c >= SW'(X_LO)) && (cx_c <= SW'(X_HI)) &&
                    (cy_c >= SW'(Y_LO)) && (cy_c <= SW'(Y_HI));
    fill_last_c   = (col_q == f_w_q - CW'(1)) && (row_q == f_h_q - CW'(1));
    fill_word_c   = in_win_c ? pack_word(cx_c[8:0], cy_c[8:0], f_color_q) : 32'h0;
  end

  // Bit 9 of the CPU coordinates has no place in the word.
  assign unused_c = ^{pix_x[9], pix_y[9]};

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      turn_q      <= TURN_CPU;
      swap_pend_q <= 1'b0;
      info_q      <= 32'h0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      f_x0_q      <= '0;
      f_y0_q      <= '0;
      f_w_q       <= '0;
      f_h_q       <= '0;
      f_color_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      fill_done_q <= 1'b0;
      info_q      <= 32'h0;
      swap_pend_q <= swap_pend_q | swap_req;
      if (fill_done_q) begin
        fill_busy_q <= 1'b0;
      end
      if (cpu_grant_c) begin
        info_q <= pack_word(pix_x[8:0], pix_y[8:0], pix_color);
      end

      case (state_q)
        IDLE: begin
          if (fill_accept_c) begin
            f_x0_q      <= fill_x0;
            f_y0_q      <= fill_y0;
            f_w_q       <= fill_w;
            f_h_q       <= fill_h;
            f_color_q   <= fill_color;
            col_q       <= '0;
            row_q       <= '0;
            fill_busy_q <= 1'b1;
            state_q     <= FILL;
          end else if (swap_pend_q) begin
            state_q <= SWAP;
          end
        end

        FILL: begin
          if (cpu_grant_c) begin
            turn_q <= TURN_FILL;
          end else begin
            turn_q <= TURN_CPU;
            if (fill_empty_c) begin
              fill_done_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              // Clipped pixels still spend their slot, emitting the no-write word.
              info_q <= fill_word_c;
              if (fill_last_c) begin
                fill_done_q <= 1'b1;
                state_q     <= IDLE;
              end else if (col_q == f_w_q - CW'(1)) begin
                col_q <= '0;
                row_q <= row_q + CW'(1);
              end else begin
                col_q <= col_q + CW'(1);
              end
            end
          end
        end

        SWAP: begin
          info_q      <= SWAP_WORD;
          swap_pend_q <= swap_req;
          state_q     <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pix_ready = pix_ready_c;
  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;
  assign info      = info_q;

endmodule
